// File: rtl/register_pkg.sv
// Shared types and constants for the serial loader and the load register.
// Holds the receiver state encoding and the default data width.
package register_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_loader.sv
// Deserializes start/data/parity/stop frames into a parallel word.
// Ports: clk, rst_ (async low), sdata/svalid in; data, enable,
// parity_err, frame_err, busy out (all registered).
module serial_loader
  import register_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             sdata,
  input  logic             svalid,
  output logic [WIDTH-1:0] data,
  output logic             enable,
  output logic             parity_err,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  rx_state_t        state, state_n;
  logic [WIDTH-1:0] shift, shift_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             perr, perr_n;
  logic [WIDTH-1:0] data_n;
  logic             enable_n;
  logic             pe_n;
  logic             fe_n;
  logic             busy_n;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state      <= IDLE;
      shift      <= '0;
      cnt        <= '0;
      perr       <= 1'b0;
      data       <= '0;
      enable     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      cnt        <= cnt_n;
      perr       <= perr_n;
      data       <= data_n;
      enable     <= enable_n;
      parity_err <= pe_n;
      frame_err  <= fe_n;
      busy       <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    shift_n  = shift;
    cnt_n    = cnt;
    perr_n   = perr;
    data_n   = data;
    enable_n = 1'b0;
    pe_n     = 1'b0;
    fe_n     = 1'b0;
    if (svalid) begin
      unique case (state)
        IDLE: begin
          if (!sdata) begin
            state_n = DATA;
            cnt_n   = '0;
            perr_n  = 1'b0;
          end
        end
        DATA: begin
          // Right shift: after WIDTH bits, bit k sits at shift[k].
          shift_n = shift >> 1;
          shift_n[WIDTH-1] = sdata;
          cnt_n = cnt + CW'(1);
          if (cnt == LAST) begin
            cnt_n   = '0;
            state_n = PARITY_EN ? PARITY : STOP;
          end
        end
        PARITY: begin
          perr_n  = (^shift) ^ sdata;
          state_n = STOP;
        end
        STOP: begin
          // A zero stop bit is an error, never a new start.
          state_n = IDLE;
          if (!sdata) begin
            fe_n = 1'b1;
          end else if (perr) begin
            pe_n = 1'b1;
          end else begin
            enable_n = 1'b1;
            data_n   = shift;
          end
        end
        default: state_n = IDLE;
      endcase
    end
    busy_n = (state_n != IDLE);
  end

endmodule
